// File: rtl/idli_sqi_mem_m.sv
// idli_sqi_mem_m -- parametrised SQI memory responder for the idli bench.
//
// Sits on the core's sck/cs/sio pins and behaves as a small quad-SPI style
// memory. Everything runs on the core clock: SCK is oversampled and its
// edges detected, never used as a clock. A transaction is one command beat
// (0x03 read, 0x02 write), ADDR_BEATS address beats (MSB first), then for
// reads DUMMY idle beats followed by data beats driven after each SCK fall,
// or for writes data beats captured on each SCK rise. The address
// auto-increments and wraps at DEPTH.
//
// Ports:
//   i_mem_gck     core clock
//   i_mem_rst_n   asynchronous active-low reset
//   i_mem_sck     SQI clock from the core (sampled)
//   i_mem_cs      chip select, active-low
//   i_mem_sio     host-to-memory beat, W = 4*LANES bits
//   o_mem_sio     memory-to-host read beat
//   o_mem_sio_oe  high while o_mem_sio is being driven
//   o_mem_err     one-cycle pulse after an unknown command

module idli_sqi_mem_m #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 16,
  parameter int DUMMY  = 1
) (
  input  logic               i_mem_gck,
  input  logic               i_mem_rst_n,
  input  logic               i_mem_sck,
  input  logic               i_mem_cs,
  input  logic [4*LANES-1:0] i_mem_sio,
  output logic [4*LANES-1:0] o_mem_sio,
  output logic               o_mem_sio_oe,
  output logic               o_mem_err
);

  localparam int W          = 4 * LANES;
  localparam int ADDR_BEATS = (ADDR_W + W - 1) / W;
  localparam int SH_W       = ADDR_BEATS * W;
  localparam int AW         = $clog2(DEPTH);
  localparam int CNT_W      = 8;

  localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(ADDR_BEATS - 1);
  localparam logic [CNT_W-1:0] DUMMY_LAST = CNT_W'((DUMMY > 0) ? DUMMY - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RD, S_WR, S_IGNORE
  } state_e;

  state_e           state_q, state_d;
  logic             sck_q;
  logic [AW-1:0]    addr_q, addr_d;
  logic [SH_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_rd_q, is_rd_d;
  logic [W-1:0]     sio_q, sio_d;
  logic             oe_q, oe_d;
  logic             err_q, err_d;
  logic             mem_we;
  logic [W-1:0]     mem_q [DEPTH];

  logic             rise, fall;
  logic [SH_W+W-1:0] shift_ext;
  logic             unused_shift_bits;

  // A deasserted chip select masks SCK edges, so CS rising together with an
  // SCK edge never advances the transaction.
  assign rise = i_mem_sck & ~sck_q & ~i_mem_cs;
  assign fall = ~i_mem_sck & sck_q & ~i_mem_cs;

  // Address bits arrive MSB first; the oldest bits fall off the top.
  assign shift_ext         = {shift_q, i_mem_sio};
  assign unused_shift_bits = ^shift_ext[SH_W+W-1:SH_W];

  assign o_mem_sio    = sio_q;
  assign o_mem_sio_oe = oe_q;
  assign o_mem_err    = err_q;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    is_rd_d = is_rd_q;
    sio_d   = sio_q;
    oe_d    = oe_q;
    err_d   = 1'b0;
    mem_we  = 1'b0;

    if (i_mem_cs) begin
      // Abandon any transaction; read data is held but no longer driven.
      state_d = S_IDLE;
      oe_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_CMD;
          shift_d = '0;
          cnt_d   = '0;
        end
        S_CMD: begin
          if (rise) begin
            shift_d = '0;
            cnt_d   = '0;
            if (i_mem_sio[7:0] == 8'h03) begin
              is_rd_d = 1'b1;
              state_d = S_ADDR;
            end else if (i_mem_sio[7:0] == 8'h02) begin
              is_rd_d = 1'b0;
              state_d = S_ADDR;
            end else begin
              err_d   = 1'b1;
              state_d = S_IGNORE;
            end
          end
        end
        S_ADDR: begin
          if (rise) begin
            shift_d = shift_ext[SH_W-1:0];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == ADDR_LAST) begin
              addr_d = shift_ext[AW-1:0];
              cnt_d  = '0;
              if (!is_rd_q)
                state_d = S_WR;
              else if (DUMMY == 0)
                state_d = S_RD;
              else
                state_d = S_DUMMY;
            end
          end
        end
        S_DUMMY: begin
          if (rise) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == DUMMY_LAST) begin
              cnt_d   = '0;
              state_d = S_RD;
            end
          end
        end
        S_RD: begin
          if (fall) begin
            sio_d  = mem_q[addr_q];
            oe_d   = 1'b1;
            addr_d = addr_q + AW'(1);
          end
        end
        S_WR: begin
          if (rise) begin
            mem_we = 1'b1;
            addr_d = addr_q + AW'(1);
          end
        end
        S_IGNORE: begin
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
    if (!i_mem_rst_n) begin
      state_q <= S_IDLE;
      sck_q   <= 1'b0;
      addr_q  <= '0;
      shift_q <= '0;
      cnt_q   <= '0;
      is_rd_q <= 1'b0;
      sio_q   <= '0;
      oe_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sck_q   <= i_mem_sck;
      addr_q  <= addr_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      is_rd_q <= is_rd_d;
      sio_q   <= sio_d;
      oe_q    <= oe_d;
      err_q   <= err_d;
    end
  end

  // Storage is deliberately not reset so contents survive a mid-transaction reset.
  always_ff @(posedge i_mem_gck) begin
    if (mem_we)
      mem_q[addr_q] <= i_mem_sio;
  end

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// tb_idli_sqi_mem_m -- directed self-checking bench for idli_sqi_mem_m.
// Instance A: LANES=2 (8-bit beats, two address beats, one dummy beat).
// Instance B: LANES=4, DUMMY=0 (16-bit beats, one address beat).
// Both share clock, reset, SCK and the host data bus; each has its own CS.

module tb_idli_sqi_mem_m;

  logic        gck;
  logic        rst_n;
  logic        sck;
  logic        cs_a;
  logic        cs_b;
  logic [15:0] sio;

  logic [7:0]  a_sio;
  logic        a_oe;
  logic        a_err;
  logic [15:0] b_sio;
  logic        b_oe;
  logic        b_err;

  int errors = 0;
  int checks = 0;

  idli_sqi_mem_m #(.LANES(2), .DEPTH(1024), .ADDR_W(16), .DUMMY(1)) dut_a (
    .i_mem_gck    (gck),
    .i_mem_rst_n  (rst_n),
    .i_mem_sck    (sck),
    .i_mem_cs     (cs_a),
    .i_mem_sio    (sio[7:0]),
    .o_mem_sio    (a_sio),
    .o_mem_sio_oe (a_oe),
    .o_mem_err    (a_err)
  );

  idli_sqi_mem_m #(.LANES(4), .DEPTH(1024), .ADDR_W(16), .DUMMY(0)) dut_b (
    .i_mem_gck    (gck),
    .i_mem_rst_n  (rst_n),
    .i_mem_sck    (sck),
    .i_mem_cs     (cs_b),
    .i_mem_sio    (sio),
    .o_mem_sio    (b_sio),
    .o_mem_sio_oe (b_oe),
    .o_mem_err    (b_err)
  );

  initial gck = 1'b0;
  always #5 gck = ~gck;

  // Safety net: the sequence is fixed-length, this only fires if it stalls.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // One SCK pulse carrying beat d. Returns one gck after the falling edge,
  // i.e. exactly when read data for that fall becomes visible.
  task automatic beat(input logic [15:0] d);
    @(negedge gck);
    sio = d;
    sck = 1'b1;
    @(negedge gck);
    @(negedge gck);
    sck = 1'b0;
    @(negedge gck);
  endtask

  task automatic start_a();
    @(negedge gck);
    cs_a = 1'b0;
    @(negedge gck);
    @(negedge gck);
  endtask

  task automatic start_b();
    @(negedge gck);
    cs_b = 1'b0;
    @(negedge gck);
    @(negedge gck);
  endtask

  task automatic end_cs();
    @(negedge gck);
    cs_a = 1'b1;
    cs_b = 1'b1;
    @(negedge gck);
    @(negedge gck);
  endtask

  task automatic write_a(input logic [15:0] addr, input logic [7:0] d0, input logic [7:0] d1);
    start_a();
    beat(16'h0002);
    beat({8'h00, addr[15:8]});
    beat({8'h00, addr[7:0]});
    beat({8'h00, d0});
    beat({8'h00, d1});
    end_cs();
  endtask

  // Command plus address; leaves instance A in the dummy phase.
  task automatic read_setup_a(input logic [15:0] addr);
    start_a();
    beat(16'h0003);
    beat({8'h00, addr[15:8]});
    beat({8'h00, addr[7:0]});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge gck);
    checks++;
    if (a_sio !== 8'h00 || a_oe !== 1'b0 || a_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_a: got sio=%h oe=%b err=%b, expected sio=00 oe=0 err=0", a_sio, a_oe, a_err);
    end
    checks++;
    if (b_sio !== 16'h0000 || b_oe !== 1'b0 || b_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_b: got sio=%h oe=%b err=%b, expected sio=0000 oe=0 err=0", b_sio, b_oe, b_err);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge gck);
  endtask

  task automatic test_write_read();
    write_a(16'h0010, 8'hA5, 8'h3C);
    read_setup_a(16'h0010);
    checks++;
    if (a_oe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL oe_before_rd: got oe=%b, expected 0", a_oe);
    end
    beat(16'h0000);
    checks++;
    if (a_sio !== 8'hA5 || a_oe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rd_first: got sio=%h oe=%b, expected sio=a5 oe=1", a_sio, a_oe);
    end
    beat(16'h0000);
    checks++;
    if (a_sio !== 8'h3C || a_oe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rd_second: got sio=%h oe=%b, expected sio=3c oe=1", a_sio, a_oe);
    end
    end_cs();
    checks++;
    if (a_sio !== 8'h3C || a_oe !== 1'b0) begin
      errors++;
      $display("[TB] FAIL cs_release: got sio=%h oe=%b, expected sio=3c oe=0", a_sio, a_oe);
    end
  endtask

  task automatic test_wrap();
    write_a(16'h03FF, 8'h11, 8'h22);
    read_setup_a(16'h03FF);
    beat(16'h0000);
    checks++;
    if (a_sio !== 8'h11) begin
      errors++;
      $display("[TB] FAIL wrap_last: got sio=%h, expected 11", a_sio);
    end
    beat(16'h0000);
    checks++;
    if (a_sio !== 8'h22) begin
      errors++;
      $display("[TB] FAIL wrap_zero: got sio=%h, expected 22", a_sio);
    end
    end_cs();
  endtask

  task automatic test_bad_cmd();
    start_a();
    @(negedge gck);
    sio = 16'h009F;
    sck = 1'b1;
    @(negedge gck);
    checks++;
    if (a_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL err_pulse: got err=%b, expected 1", a_err);
    end
    @(negedge gck);
    checks++;
    if (a_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL err_single: got err=%b, expected 0", a_err);
    end
    sck = 1'b0;
    @(negedge gck);
    // Beats that would look like a write to 0x0010 if decoded.
    beat(16'h0000);
    beat(16'h0010);
    beat(16'h00FF);
    checks++;
    if (a_oe !== 1'b0 || a_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ignore_quiet: got oe=%b err=%b, expected oe=0 err=0", a_oe, a_err);
    end
    end_cs();
    read_setup_a(16'h0010);
    beat(16'h0000);
    checks++;
    if (a_sio !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL ignore_no_write: got sio=%h, expected a5", a_sio);
    end
    end_cs();
  endtask

  task automatic test_partial_addr();
    start_a();
    beat(16'h0003);
    beat(16'h0000);
    end_cs();
    read_setup_a(16'h0000);
    beat(16'h0000);
    checks++;
    if (a_sio !== 8'h22 || a_oe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL partial_addr: got sio=%h oe=%b, expected sio=22 oe=1", a_sio, a_oe);
    end
    end_cs();
  endtask

  task automatic test_cs_wins();
    write_a(16'h0020, 8'h55, 8'h77);
    start_a();
    beat(16'h0002);
    beat(16'h0000);
    beat(16'h0021);
    // CS rises in the same cycle as SCK: this beat must not be written.
    @(negedge gck);
    sio  = 16'h0066;
    sck  = 1'b1;
    cs_a = 1'b1;
    @(negedge gck);
    @(negedge gck);
    sck = 1'b0;
    @(negedge gck);
    @(negedge gck);
    read_setup_a(16'h0020);
    beat(16'h0000);
    checks++;
    if (a_sio !== 8'h55) begin
      errors++;
      $display("[TB] FAIL cs_wins_first: got sio=%h, expected 55", a_sio);
    end
    beat(16'h0000);
    checks++;
    if (a_sio !== 8'h77) begin
      errors++;
      $display("[TB] FAIL cs_wins_second: got sio=%h, expected 77", a_sio);
    end
    end_cs();
  endtask

  task automatic test_lanes4();
    start_b();
    beat(16'h0002);
    beat(16'h0005);
    beat(16'hDEAD);
    beat(16'hBEEF);
    end_cs();
    start_b();
    beat(16'h0003);
    beat(16'h0005);
    checks++;
    if (b_sio !== 16'hDEAD || b_oe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lanes4_first: got sio=%h oe=%b, expected sio=dead oe=1", b_sio, b_oe);
    end
    beat(16'h0000);
    checks++;
    if (b_sio !== 16'hBEEF || b_oe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL lanes4_second: got sio=%h oe=%b, expected sio=beef oe=1", b_sio, b_oe);
    end
    end_cs();
    checks++;
    if (a_oe !== 1'b0 || a_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL lanes4_a_idle: got oe=%b err=%b, expected oe=0 err=0", a_oe, a_err);
    end
  endtask

  task automatic test_reset_mid_rd();
    read_setup_a(16'h0010);
    beat(16'h0000);
    checks++;
    if (a_oe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pre_reset_oe: got oe=%b, expected 1", a_oe);
    end
    @(negedge gck);
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_oe !== 1'b0 || a_sio !== 8'h00) begin
      errors++;
      $display("[TB] FAIL async_reset: got sio=%h oe=%b, expected sio=00 oe=0", a_sio, a_oe);
    end
    @(negedge gck);
    cs_a = 1'b1;
    @(negedge gck);
    rst_n = 1'b1;
    @(negedge gck);
    read_setup_a(16'h0010);
    beat(16'h0000);
    checks++;
    if (a_sio !== 8'hA5) begin
      errors++;
      $display("[TB] FAIL post_reset_first: got sio=%h, expected a5", a_sio);
    end
    beat(16'h0000);
    checks++;
    if (a_sio !== 8'h3C) begin
      errors++;
      $display("[TB] FAIL post_reset_second: got sio=%h, expected 3c", a_sio);
    end
    end_cs();
  endtask

  initial begin
    rst_n = 1'b0;
    sck   = 1'b0;
    cs_a  = 1'b1;
    cs_b  = 1'b1;
    sio   = 16'h0000;
    test_reset();
    test_write_read();
    test_wrap();
    test_bad_cmd();
    test_partial_addr();
    test_cs_wins();
    test_lanes4();
    test_reset_mid_rd();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
